// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU stage between operand fetch and writeback.
// Single-cycle AND/OR/NOR/ADD/SUB/SLT share one adder. MUL is an iterative
// shift-add multiplier that returns the low half of the product.
// Handshake is valid/ready on both sides. Upstream is stalled while a
// multiply runs or while downstream holds a result.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      mul_cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               overflow_q;

  logic               accept;
  logic               is_mul;

  logic [WIDTH-1:0]   b_op;
  logic               cin;
  logic [WIDTH:0]     sum_ext;
  logic               add_ovf;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL) && (MUL_EN != 0);

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = out_valid_q && (result_q == '0);

  // Single-cycle datapath: one adder computes A+B or A+~B+1, then the op selects the result and flags.
  always_comb begin
    b_op      = in2;
    cin       = 1'b0;
    if (op == OP_SUB || op == OP_SLT) begin
      b_op = ~in2;
      cin  = 1'b1;
    end
    sum_ext   = {1'b0, in1} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    add_ovf   = (in1[WIDTH-1] == b_op[WIDTH-1]) && (sum_ext[WIDTH-1] != in1[WIDTH-1]);
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_AND: alu_res = in1 & in2;
      OP_OR:  alu_res = in1 | in2;
      OP_NOR: alu_res = ~(in1 | in2);
      OP_ADD, OP_SUB: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SLT: begin
        alu_res   = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ add_ovf};
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = add_ovf;
      end
      default: alu_res = '0;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a multiply occupies WIDTH iteration cycles plus one cycle to publish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (mul_cnt == CW'(WIDTH - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiplier: operands are latched on accept, then one multiplier bit is consumed per cycle, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && is_mul) begin
            mul_cnt <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, in1};
            mplier  <= in2;
          end
        end
        MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + CW'(1);
        end
        default: begin
          mul_cnt <= '0;
        end
      endcase
    end
  end

  // Output registers: load on a finished multiply or a single-cycle accept, otherwise drain when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (state_q == DONE) begin
      out_valid_q <= 1'b1;
      result_q    <= acc[WIDTH-1:0];
      carry_q     <= |acc[2*WIDTH-1:WIDTH];
      overflow_q  <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      carry_q     <= alu_carry;
      overflow_q  <= alu_ovf;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
